// File: rtl/aes_128.sv
// aes_128: free-running AES-128 encryption pipeline, no stall and no valid.
// A block sampled on `state` at one rising edge appears on `out` 21 register
// stages later. The key travels down the pipeline with its block, so every
// block may use a different key.
//
// Ports:
//   clk   in  1    clock, rising edge
//   state in  128  plaintext block (byte 0 in bits [127:120])
//   key   in  128  cipher key for the block sampled this cycle
//   out   out 128  ciphertext block
//
// Stage layout: 1 initial AddRoundKey stage, then two stages per round
// (SubBytes+ShiftRows with key expansion, then MixColumns+AddRoundKey).
module aes_128 (
    input  logic         clk,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as x^254 (GF(2^8) inverse, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte index r+4c (column-major); row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int rnd);
        case (rnd)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] r_s [0:20];
    logic [127:0] r_k [0:19];

    always_ff @(posedge clk) begin
        r_s[0] <= state ^ key;
        r_k[0] <= key;
    end

    for (genvar g = 1; g <= 10; g++) begin : g_round
        always_ff @(posedge clk) begin
            r_s[2*g-1] <= shift_rows(sub_bytes(r_s[2*g-2]));
            r_k[2*g-1] <= next_key(r_k[2*g-2], rcon(g));
        end
        if (g < 10) begin : g_mid
            always_ff @(posedge clk) begin
                r_s[2*g] <= mix_columns(r_s[2*g-1]) ^ r_k[2*g-1];
                r_k[2*g] <= r_k[2*g-1];
            end
        end else begin : g_final
            // Final round has no MixColumns.
            always_ff @(posedge clk) begin
                r_s[20] <= r_s[19] ^ r_k[19];
            end
        end
    end

    assign out = r_s[20];

endmodule

// File: rtl/aes_128_ctr_dec.sv
// aes_128_ctr_dec: AES-128 counter-mode decryptor around the aes_128 pipeline.
// Accepted ciphertext beats push one counter block each into aes_128; a
// valid/last/data delay line matching the core latency lines the ciphertext
// up with its keystream, and the plaintext lands in an output FIFO. Input
// credit (in-flight + buffered < FIFO_DEPTH) guarantees the FIFO never
// overflows, since the core cannot stall.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start, key[128], iv[128]       begin a message (honoured only when idle)
//   busy                           message in progress (RUN or DRAIN)
//   ct_valid/ct_ready/ct_data/ct_last   ciphertext input stream
//   pt_valid/pt_ready/pt_data/pt_last   plaintext output stream
//
// Build option: define AES_128_CTR_DEC_CTR32_EN to increment only ctr[31:0]
// (mod 2^32); otherwise the whole 128-bit counter increments.
module aes_128_ctr_dec #(
    parameter int unsigned AES_LAT    = 21,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    output logic         busy,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [127:0] ct_data,
    input  logic         ct_last,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [127:0] pt_data,
    output logic         pt_last
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0] DepthW = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    function automatic logic [127:0] ctr_inc(input logic [127:0] c);
`ifdef AES_128_CTR_DEC_CTR32_EN
        return {c[127:32], c[31:0] + 32'd1};
`else
        return c + 128'd1;
`endif
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_e             r_state;
    logic [127:0]       r_key;
    logic [127:0]       r_ctr;
    logic [AES_LAT-1:0] r_dl_vld;
    logic [AES_LAT-1:0] r_dl_last;
    logic [127:0]       r_dl_data [AES_LAT];
    logic [128:0]       r_fifo [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_inflight;

    logic [127:0]       w_keystream;
    logic [CW:0]        w_used;
    logic               w_accept;
    logic               w_retire;
    logic               w_pop;

    aes_128 u_aes (
        .clk   (clk),
        .state (r_ctr),
        .key   (r_key),
        .out   (w_keystream)
    );

    // Credit uses registered counts only; a pop this cycle frees space next cycle.
    assign w_used   = {1'b0, r_inflight} + {1'b0, r_count};
    assign ct_ready = (r_state == StRun) && (w_used < DepthW);
    assign w_accept = ct_valid && ct_ready;
    assign w_retire = r_dl_vld[AES_LAT-1];
    assign pt_valid = (r_count != '0);
    assign w_pop    = pt_valid && pt_ready;
    assign pt_data  = pt_valid ? r_fifo[r_rd_ptr][127:0] : '0;
    assign pt_last  = pt_valid && r_fifo[r_rd_ptr][128];
    assign busy     = (r_state != StIdle);

    // Control FSM with key and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_key   <= '0;
            r_ctr   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_key   <= key;
                        r_ctr   <= iv;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_accept) begin
                        r_ctr <= ctr_inc(r_ctr);
                        if (ct_last) r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_inflight == '0 && r_count == '0) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Delay line: valid is reset, payload just follows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dl_vld <= '0;
        end else begin
            r_dl_vld <= {r_dl_vld[AES_LAT-2:0], w_accept};
        end
        r_dl_last    <= {r_dl_last[AES_LAT-2:0], ct_last};
        r_dl_data[0] <= ct_data;
        for (int i = 1; i < AES_LAT; i++) r_dl_data[i] <= r_dl_data[i-1];
    end

    // Output FIFO and in-flight accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_retire) begin
                r_fifo[r_wr_ptr] <= {r_dl_last[AES_LAT-1], w_keystream ^ r_dl_data[AES_LAT-1]};
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_retire, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_ctr_dec.sv
// Directed bench for aes_128_ctr_dec: NIST CTR vectors, counter wrap,
// backpressure with credit limit, start-in-RUN, and mid-message reset.
module tb_aes_128_ctr_dec;

    localparam int unsigned AES_LAT    = 21;
    localparam int unsigned FIFO_DEPTH = 32;
    localparam int          Budget     = 2000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [127:0] iv;
    logic         busy;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct_data;
    logic         ct_last;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] pt_data;
    logic         pt_last;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_128_ctr_dec #(
        .AES_LAT    (AES_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .iv       (iv),
        .busy     (busy),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .ct_last  (ct_last),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .pt_last  (pt_last)
    );

    // ---------------- reference AES model (table-driven) ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from walking the multiplicative group by 3 and 1/3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] blk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rk [16];
        logic [7:0]   a0, a1, a2, a3, rc, k0, k1, k2, k3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127-8*i -: 8];
            s[i]  = blk[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            k0 = sb[rk[13]] ^ rc; k1 = sb[rk[14]]; k2 = sb[rk[15]]; k3 = sb[rk[12]];
            rk[0] = rk[0] ^ k0; rk[1] = rk[1] ^ k1; rk[2] = rk[2] ^ k2; rk[3] = rk[3] ^ k3;
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] model_inc(input logic [127:0] c);
`ifdef AES_128_CTR_DEC_CTR32_EN
        return {c[127:32], c[31:0] + 32'd1};
`else
        return c + 128'd1;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [127:0] tx_d [$];
    logic         tx_l [$];
    logic [127:0] ex_d [$];
    logic         ex_l [$];
    int           first_lat;
    int           acc_at_hold;
    logic         rdy_at_hold;

    task automatic clear_q();
        tx_d.delete(); tx_l.delete(); ex_d.delete(); ex_l.delete();
    endtask

    task automatic add(input logic [127:0] c, input logic l, input logic [127:0] p);
        tx_d.push_back(c); tx_l.push_back(l); ex_d.push_back(p); ex_l.push_back(l);
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] v);
        @(negedge clk);
        start = 1'b1; key = k; iv = v;
        @(negedge clk);
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk1(tag, busy, 1'b0);
    endtask

    // Runs send and receive together on negedges. pt_ready is held low for
    // the first `hold` cycles; a start pulse is driven once when `pulse_at`
    // beats have been accepted.
    task automatic stream(input string tag, input int hold, input int pulse_at);
        int cyc, ti, ri, acc_cyc;
        bit pulsed;
        cyc = 0; ti = 0; ri = 0; acc_cyc = -1; pulsed = 1'b0; first_lat = -1;
        while ((ti < tx_d.size() || ri < ex_d.size()) && cyc < Budget) begin
            @(negedge clk);
            pt_ready = (cyc >= hold);
            if (cyc == hold) begin
                acc_at_hold = ti;
                rdy_at_hold = ct_ready;
            end
            if (pt_valid) begin
                if (first_lat < 0 && acc_cyc >= 0) first_lat = cyc - acc_cyc;
                if (pt_ready) begin
                    if (ri < ex_d.size()) begin
                        chk($sformatf("%s_data[%0d]", tag, ri), pt_data, ex_d[ri]);
                        chk1($sformatf("%s_last[%0d]", tag, ri), pt_last, ex_l[ri]);
                    end else begin
                        chk1($sformatf("%s_extra_out", tag), pt_valid, 1'b0);
                    end
                    ri++;
                end
            end
            if (ti == pulse_at && !pulsed) begin
                start = 1'b1; key = ~key; iv = ~iv; ct_valid = 1'b0; pulsed = 1'b1;
            end else begin
                start = 1'b0;
                if (ti < tx_d.size()) begin
                    ct_valid = 1'b1; ct_data = tx_d[ti]; ct_last = tx_l[ti];
                    if (ct_ready) begin
                        if (acc_cyc < 0) acc_cyc = cyc;
                        ti++;
                    end
                end else begin
                    ct_valid = 1'b0;
                end
            end
            cyc++;
        end
        chk1($sformatf("%s_in_time", tag), cyc < Budget, 1'b1);
        @(negedge clk);
        ct_valid = 1'b0; ct_last = 1'b0; start = 1'b0; pt_ready = 1'b1;
    endtask

    localparam logic [127:0] KeyF5 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IvF5  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] Ks00  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] Ks01  = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    task automatic add_f5();
        add(128'h874d6191b620e3261bef6864990db6ce, 1'b0, 128'h6bc1bee22e409f96e93d7e117393172a);
        add(128'h9806f66b7970fdff8617187bb9fffdff, 1'b0, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
        add(128'h5ae4df3edbd5d35e5b4f09020db03eab, 1'b0, 128'h30c81c46a35ce411e5fbc1191a0a52ef);
        add(128'h1e031dda2fbe03d1792170a0f3009cee, 1'b1, 128'hf69f2445df4f9b17ad2b417be66c3710);
    endtask

    initial begin
        logic [127:0] ctr;
        logic [127:0] c;
        logic [127:0] exp2;
        logic [31:0]  w;
        int           stale;

        build_sbox();
        rst_n = 1'b0; start = 1'b0; key = '0; iv = '0;
        ct_valid = 1'b0; ct_data = '0; ct_last = 1'b0; pt_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk1("rst_ct_ready", ct_ready, 1'b0);
        chk1("rst_pt_valid", pt_valid, 1'b0);
        chk("rst_pt_data", pt_data, '0);
        chk1("rst_pt_last", pt_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);

        // SP800-38A F.5.2
        clear_q(); add_f5();
        load(KeyF5, IvF5);
        stream("f52", 0, -1);
        chki("f52_latency", first_lat, AES_LAT + 1);
        wait_idle("f52_idle");

        // Zero key, zero counter
        clear_q();
        add('0, 1'b0, Ks00);
        add('0, 1'b1, Ks01);
        load('0, '0);
        stream("kv", 0, -1);
        wait_idle("kv_idle");

        // Counter wrap from all ones
        clear_q();
`ifdef AES_128_CTR_DEC_CTR32_EN
        exp2 = aes_model('0, {96'hffffffff_ffffffff_ffffffff, 32'h0});
`else
        exp2 = Ks00;
`endif
        add('0, 1'b0, aes_model('0, {128{1'b1}}));
        add('0, 1'b1, exp2);
        load('0, {128{1'b1}});
        stream("wrap", 0, -1);
        wait_idle("wrap_idle");

        // start pulsed mid-message must not disturb key or counter
        clear_q(); add_f5();
        load(KeyF5, IvF5);
        stream("ign", 0, 2);
        wait_idle("ign_idle");

        // Backpressure: 40 beats with pt_ready held low for 80 cycles
        clear_q();
        ctr = IvF5;
        for (int i = 0; i < 40; i++) begin
            w = 32'(i) * 32'h9e3779b9;
            c = {w, ~w, w ^ 32'h5a5a5a5a, w + 32'd1};
            add(c, (i == 39), aes_model(KeyF5, ctr) ^ c);
            ctr = model_inc(ctr);
        end
        load(KeyF5, IvF5);
        stream("bp", 80, -1);
        chki("bp_accepts_at_stall", acc_at_hold, FIFO_DEPTH);
        chk1("bp_ready_low_at_stall", rdy_at_hold, 1'b0);
        wait_idle("bp_idle");

        // Reset with 10 blocks in flight
        clear_q();
        for (int i = 0; i < 10; i++) begin
            tx_d.push_back({4{32'(i) + 32'h1000}});
            tx_l.push_back(1'b0);
        end
        load(KeyF5, IvF5);
        stream("mr_send", 0, -1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk1("mr_ct_ready", ct_ready, 1'b0);
        chk1("mr_pt_valid", pt_valid, 1'b0);
        chk("mr_pt_data", pt_data, '0);
        chk1("mr_pt_last", pt_last, 1'b0);
        chk1("mr_busy", busy, 1'b0);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (pt_valid) stale++;
        end
        chki("mr_no_stale_valid", stale, 0);

        clear_q(); add_f5();
        load(KeyF5, IvF5);
        stream("mr_f52", 0, -1);
        wait_idle("mr_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_128_ctr_dec.md
# aes_128_ctr_dec

AES-128 counter-mode decryptor wrapped around the existing free-running `aes_128` pipeline (`clk`, `state`, `key`, `out`). The block generates counter blocks, pushes one per accepted ciphertext beat into `aes_128`, and XORs the resulting keystream with the delayed ciphertext. The plaintext goes to a valid/ready output stream. `aes_128` has no stall or valid, so this block does the valid tracking, credit-based flow control and output buffering. It is the receive-side counterpart to the encrypt datapath.

## Interface
- `AES_LAT`, 21: cycles from `aes_128` sampling `state` to `out` holding that block's result. Must match the instantiated core.
- `FIFO_DEPTH`, 32: output FIFO entries, ≥1. Full throughput requires ≥ AES_LAT+1.
- `clk` in 1: the single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: load `key`/`iv` and begin a message. Honoured only in IDLE.
- `key` in 128: AES key, sampled on an honoured `start`.
- `iv` in 128: initial counter block, sampled on an honoured `start`.
- `busy` out 1: high in RUN and DRAIN.
- `ct_valid` in 1, `ct_ready` out 1, `ct_data` in 128, `ct_last` in 1: ciphertext input stream.
- `pt_valid` out 1, `pt_ready` in 1, `pt_data` out 128, `pt_last` out 1: plaintext output stream.

## Operation
- **Registers:** `key_r`, `ctr_r`, a valid/last delay line and a ct-data delay line (each AES_LAT deep), an output FIFO, an in-flight counter and the FSM.
- **Core connection:** `aes_128.state = ctr_r` and `aes_128.key = key_r` at all times. The core pipelines its key, so each block carries its own key.
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE: `ct_ready`=0. On `start`, load `key_r`←`key` and `ctr_r`←`iv`, then go to RUN.
  - RUN: accept beats. A beat accepted with `ct_last`=1 moves to DRAIN.
  - DRAIN: `ct_ready`=0. When in-flight = 0 and FIFO is empty, go to IDLE.
  - `start` in RUN or DRAIN is ignored.
- **Accept rule:** `ct_ready` = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH). Both counts are the current registered values; a same-cycle pop gives no credit.
- **On accept** (`ct_valid && ct_ready`):
  - Shift valid=1 with `ct_last` and `ct_data` into the delay lines. Otherwise shift valid=0.
  - Increment `ctr_r` (see Configuration).
  - Increment inflight.
- **On delay-line output valid:**
  - Write `{last, out ^ ct_delayed}` into the FIFO. The credit rule guarantees the FIFO is never full here.
  - Decrement inflight.
- **Simultaneous events:**
  - Accept and retire in the same cycle: inflight unchanged.
  - FIFO write and pop in the same cycle: count unchanged.
- **Output:** `pt_valid` = FIFO not empty. `pt_data`/`pt_last` show the FIFO head and hold while `pt_valid && !pt_ready`. An entry pops on `pt_valid && pt_ready`.
- **Reset values:** `ct_ready`=0, `pt_valid`=0, `pt_data`=0, `pt_last`=0, `busy`=0, state IDLE, FIFO empty, inflight 0, delay-line valids 0.
- **Reset mid-operation:** all in-flight and buffered blocks are discarded. `aes_128` contents are don't-care because all valids are cleared.

## Timing
- A beat accepted at edge E is written to the FIFO at edge E+AES_LAT. `pt_valid` is high in the cycle after edge E+AES_LAT if the FIFO was empty.
- Throughput is 1 block/cycle when `pt_ready`=1 and FIFO_DEPTH ≥ AES_LAT+1.
- Output order equals input order. `pt_last` marks the block derived from the `ct_last` beat.
- `busy` falls in the cycle after the last FIFO pop of a message.

## Configuration
- `AES_128_CTR_DEC_CTR32_EN` defined: increment only `ctr_r[31:0]` mod 2^32; `ctr_r[127:32]` is unchanged (GCM-style).
- Not defined: full 128-bit increment mod 2^128. All-ones wraps to zero.

## Test plan
- **SP800-38A F.5.2:** `key`=2b7e1516_28aed2a6_abf71588_09cf4f3c, `iv`=f0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff.
  - Stimulus: ct 874d6191b620e3261bef6864990db6ce, 9806f66b7970fdff8617187bb9fffdff, 5ae4df3edbd5d35e5b4f09020db03eab, 1e031dda2fbe03d1792170a0f3009cee (last).
  - Required: pt 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51, 30c81c46a35ce411e5fbc1191a0a52ef, f69f2445df4f9b17ad2b417be66c3710. `pt_last` set only on the 4th block; first `pt_valid` AES_LAT+1 cycles after the first accept.
- **Known-vector counter:** `key`=0, `iv`=0, ct=0,0 -> pt 66e94bd4ef8a2c3b884cfa59ca342b2e, then 58e2fccefa7e3061367f1d57a4e7455a.
- **Counter wrap:** `key`=0, `iv`=all ones, two zero ct blocks.
  - Without the macro: 2nd pt = 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - With the macro: 2nd pt ≠ that value and equals the model of AES(0, ffffffff_ffffffff_ffffffff_00000000).
- **Backpressure:** hold `pt_ready`=0 and offer 40 beats. `ct_ready` must fall after exactly FIFO_DEPTH accepts. Then release `pt_ready`: all 40 outputs arrive in order, with no loss or duplication.
- **Protocol edges:**
  - `start` pulsed during RUN is ignored; key and counter are unchanged.
  - `rst_n`=0 for one cycle with 10 blocks in flight: all outputs take reset values next cycle, no stale `pt_valid` follows, and a subsequent message decrypts correctly.
